// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle for the multiply/divide sequencer.
// Also provides the shared ALU operation codes for the M-extension ops.
// Each code is guarded so that an existing shared definition takes precedence.
`ifndef ALU_MUL_OP
`define ALU_MUL_OP    5'd10
`endif
`ifndef ALU_MULH_OP
`define ALU_MULH_OP   5'd11
`endif
`ifndef ALU_MULHSU_OP
`define ALU_MULHSU_OP 5'd12
`endif
`ifndef ALU_MULHU_OP
`define ALU_MULHU_OP  5'd13
`endif
`ifndef ALU_DIV_OP
`define ALU_DIV_OP    5'd14
`endif
`ifndef ALU_DIVU_OP
`define ALU_DIVU_OP   5'd15
`endif
`ifndef ALU_REM_OP
`define ALU_REM_OP    5'd16
`endif
`ifndef ALU_REMU_OP
`define ALU_REMU_OP   5'd17
`endif

interface muldiv_sequencer_if;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;

    modport master (output start, op, a, b, input result, busy, done);
    modport slave  (input start, op, a, b, output result, busy, done);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 shift-add multiplier and restoring divider sharing
// one 64-bit hi/lo accumulator, sequenced by an IDLE/RUN/DONE FSM.
// Compile-time option: MULDIV_SEQUENCER_FAST_MUL_EN makes all multiplies single-cycle.
module muldiv_sequencer (
    input  logic              clock,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, bmag_q, bmag_d, result_q, result_d;
    logic                mul_q, mul_d, sel_hi_q, sel_hi_d, neg_q, neg_d, dvd_neg_q, dvd_neg_d;

    logic                in_mul, in_div, in_rem, in_lo, a_sgn, b_sgn;
    logic                a_neg, b_neg, div_zero, div_ovf, fast_mul, bypass, accept, last_step;
    logic [DATA_W-1:0]   a_mag, b_mag, fast_res, bypass_res;
    logic [2*DATA_W-1:0] step_res, prod_fix;

    function automatic logic [DATA_W-1:0] cneg32(input logic n, input logic [DATA_W-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] cneg64(input logic n, input logic [2*DATA_W-1:0] v);
        return n ? -v : v;
    endfunction

    // One shift-add step: add the multiplicand into hi when the current multiplier bit
    // is set, then shift the whole {hi,lo} pair right by one.
    function automatic logic [2*DATA_W-1:0] mul_step(input logic [DATA_W-1:0] hi,
                                                     input logic [DATA_W-1:0] lo,
                                                     input logic [DATA_W-1:0] mc);
        logic [DATA_W:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
        return {sum, lo[DATA_W-1:1]};
    endfunction

    // One restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits; the borrow bit decides the quotient bit.
    function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                     input logic [DATA_W-1:0] quo,
                                                     input logic [DATA_W-1:0] dvs);
        logic [DATA_W:0] sh;
        logic [DATA_W:0] diff;
        sh   = {rem, quo[DATA_W-1]};
        diff = sh - {1'b0, dvs};
        if (!diff[DATA_W]) return {diff[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
        else               return {sh[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
    endfunction

    // Decode the incoming op into unit select and operand signedness.
    always_comb begin
        in_mul = 1'b0;
        in_div = 1'b0;
        in_rem = 1'b0;
        in_lo  = 1'b0;
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        case (bus.op)
            `ALU_MUL_OP:    begin in_mul = 1'b1; in_lo = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            `ALU_MULH_OP:   begin in_mul = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            `ALU_MULHSU_OP: begin in_mul = 1'b1; a_sgn = 1'b1; end
            `ALU_MULHU_OP:  begin in_mul = 1'b1; end
            `ALU_DIV_OP:    begin in_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            `ALU_DIVU_OP:   begin in_div = 1'b1; end
            `ALU_REM_OP:    begin in_div = 1'b1; in_rem = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            `ALU_REMU_OP:   begin in_div = 1'b1; in_rem = 1'b1; end
            default:        ;
        endcase
    end

    assign a_neg    = a_sgn & bus.a[DATA_W-1];
    assign b_neg    = b_sgn & bus.b[DATA_W-1];
    assign a_mag    = cneg32(a_neg, bus.a);
    assign b_mag    = cneg32(b_neg, bus.b);
    assign div_zero = in_div && (bus.b == '0);
    assign div_ovf  = in_div && a_sgn && (bus.a == {1'b1, {(DATA_W-1){1'b0}}}) && (bus.b == '1);

`ifdef MULDIV_SEQUENCER_FAST_MUL_EN
    // Full-width product computed from sign- or zero-extended operands; the low 64 bits
    // are exact for every signedness combination.
    logic signed [2*DATA_W-1:0] fast_a, fast_b, fast_p;
    assign fast_a   = {{DATA_W{a_sgn & bus.a[DATA_W-1]}}, bus.a};
    assign fast_b   = {{DATA_W{b_sgn & bus.b[DATA_W-1]}}, bus.b};
    assign fast_p   = fast_a * fast_b;
    assign fast_mul = in_mul;
    assign fast_res = in_lo ? fast_p[DATA_W-1:0] : fast_p[2*DATA_W-1:DATA_W];
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    assign accept    = bus.start && (state_q != S_RUN);
    assign bypass    = (!in_mul && !in_div) || div_zero || div_ovf || fast_mul;
    assign last_step = (cnt_q == '1);

    // Result for ops that skip RUN; non-M ops fall through to zero.
    always_comb begin
        bypass_res = '0;
        if (fast_mul)      bypass_res = fast_res;
        else if (div_zero) bypass_res = in_rem ? bus.a : '1;
        else if (div_ovf)  bypass_res = in_rem ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: accept from IDLE/DONE, iterate 32 cycles in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = bypass ? S_DONE : S_RUN;
                else        state_d = S_IDLE;
            end
            S_RUN:   state_d = last_step ? S_DONE : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        bus.busy   = (state_q == S_RUN);
        bus.done   = (state_q == S_DONE);
        bus.result = result_q;
    end

    // Datapath next-state: load operands on accept, step each RUN cycle, and apply
    // sign correction to the final step's output as the result is captured.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bmag_d    = bmag_q;
        mul_d     = mul_q;
        sel_hi_d  = sel_hi_q;
        neg_d     = neg_q;
        dvd_neg_d = dvd_neg_q;
        result_d  = result_q;
        step_res  = mul_q ? mul_step(hi_q, lo_q, bmag_q) : div_step(hi_q, lo_q, bmag_q);
        prod_fix  = cneg64(neg_q, step_res);
        if (accept) begin
            cnt_d     = '0;
            hi_d      = '0;
            lo_d      = a_mag;
            bmag_d    = b_mag;
            mul_d     = in_mul;
            sel_hi_d  = in_mul ? !in_lo : in_rem;
            neg_d     = a_neg ^ b_neg;
            dvd_neg_d = a_neg;
            if (bypass) result_d = bypass_res;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
            hi_d  = step_res[2*DATA_W-1:DATA_W];
            lo_d  = step_res[DATA_W-1:0];
            if (last_step) begin
                if (mul_q)         result_d = sel_hi_q ? prod_fix[2*DATA_W-1:DATA_W] : prod_fix[DATA_W-1:0];
                else if (sel_hi_q) result_d = cneg32(dvd_neg_q, step_res[2*DATA_W-1:DATA_W]);
                else               result_d = cneg32(neg_q, step_res[DATA_W-1:0]);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            bmag_q    <= '0;
            mul_q     <= 1'b0;
            sel_hi_q  <= 1'b0;
            neg_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            bmag_q    <= bmag_d;
            mul_q     <= mul_d;
            sel_hi_q  <= sel_hi_d;
            neg_q     <= neg_d;
            dvd_neg_q <= dvd_neg_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer with directed and random ops.
`ifndef ALU_MUL_OP
`define ALU_MUL_OP    5'd10
`endif
`ifndef ALU_MULH_OP
`define ALU_MULH_OP   5'd11
`endif
`ifndef ALU_MULHSU_OP
`define ALU_MULHSU_OP 5'd12
`endif
`ifndef ALU_MULHU_OP
`define ALU_MULHU_OP  5'd13
`endif
`ifndef ALU_DIV_OP
`define ALU_DIV_OP    5'd14
`endif
`ifndef ALU_DIVU_OP
`define ALU_DIVU_OP   5'd15
`endif
`ifndef ALU_REM_OP
`define ALU_REM_OP    5'd16
`endif
`ifndef ALU_REMU_OP
`define ALU_REMU_OP   5'd17
`endif

module tb_muldiv_sequencer;
    logic clock = 1'b0;
    logic reset;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef MULDIV_SEQUENCER_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        int unsigned edge_n;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned edge_cnt  = 0;
    int unsigned busy_last = 0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on sign- or zero-extended operands.
    function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = '0;
        case (o)
            `ALU_MUL_OP:    begin p = sx * sy; return p[31:0];  end
            `ALU_MULH_OP:   begin p = sx * sy; return p[63:32]; end
            `ALU_MULHSU_OP: begin p = sx * uy; return p[63:32]; end
            `ALU_MULHU_OP:  begin p = ux * uy; return p[63:32]; end
            `ALU_DIV_OP: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sx / sy; return p[31:0];
            end
            `ALU_REM_OP: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            `ALU_DIVU_OP: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            `ALU_REMU_OP: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    // Whether the op completes one cycle after acceptance instead of 33.
    function automatic logic ref_bypass(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic is_mul, is_div, is_sdiv;
        is_mul  = o inside {`ALU_MUL_OP, `ALU_MULH_OP, `ALU_MULHSU_OP, `ALU_MULHU_OP};
        is_div  = o inside {`ALU_DIV_OP, `ALU_DIVU_OP, `ALU_REM_OP, `ALU_REMU_OP};
        is_sdiv = o inside {`ALU_DIV_OP, `ALU_REM_OP};
        if (!is_mul && !is_div) return 1'b1;
        if (is_mul) return FAST;
        return (y == 0) || (is_sdiv && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Drive a start for one edge (called at a negedge); the bench's own busy window
    // decides whether the edge will accept it.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        int unsigned n;
        logic        byp;
        n   = edge_cnt + 1;
        byp = ref_bypass(o, x, y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        if (n > busy_last) begin
            e.res     = ref_result(o, x, y);
            e.edge_n  = byp ? n : n + 32;
            busy_last = e.edge_n;
            sb_q.push_back(e);
        end
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < 60) begin
            @(negedge clock);
            k++;
        end
        if (k >= 60) check("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    // Monitor: every done cycle retires one scoreboard entry.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("done_without_request", {31'd0, bus.done}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", bus.result, mon_e.res);
                check("done_cycle", edge_cnt, mon_e.edge_n);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    logic [4:0]  d_op  [13];
    logic [31:0] d_a   [13];
    logic [31:0] d_b   [13];
    logic [31:0] d_exp [13];
    logic [4:0]  ops   [9];

    initial begin
        logic [4:0]  o;
        logic [31:0] x, y;
        logic        byp;

        d_op  = '{`ALU_MUL_OP, `ALU_MULH_OP, `ALU_MULHU_OP, `ALU_MULHSU_OP, `ALU_DIV_OP, `ALU_REM_OP,
                  `ALU_DIVU_OP, `ALU_REMU_OP, `ALU_DIVU_OP, `ALU_REMU_OP, `ALU_DIV_OP, `ALU_REM_OP, 5'd0};
        d_a   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                  32'd100, 32'd100, 32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd1234};
        d_b   = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd99};
        d_exp = '{32'h2A, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                  32'd14, 32'd2, 32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'h0, 32'h0};
        ops   = '{`ALU_MUL_OP, `ALU_MULH_OP, `ALU_MULHSU_OP, `ALU_MULHU_OP,
                  `ALU_DIV_OP, `ALU_DIVU_OP, `ALU_REM_OP, `ALU_REMU_OP, 5'd0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clock);
        check("reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("reset_done",   {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        reset = 1'b0;

        // Directed cases; the first start lands on the edge right after reset release.
        for (int i = 0; i < 13; i++) begin
            byp = ref_bypass(d_op[i], d_a[i], d_b[i]);
            check("model_vs_table", ref_result(d_op[i], d_a[i], d_b[i]), d_exp[i]);
            issue(d_op[i], d_a[i], d_b[i]);
            check("busy_after_accept", {31'd0, bus.busy}, {31'd0, !byp});
            wait_done();
            repeat (2) @(negedge clock);
            check("result_hold", bus.result, d_exp[i]);
        end

        // Start during RUN is ignored and the first result survives.
        issue(`ALU_DIVU_OP, 32'd1000, 32'd7);
        repeat (4) @(negedge clock);
        check("busy_mid_run", {31'd0, bus.busy}, 32'd1);
        issue(`ALU_DIVU_OP, 32'd50, 32'd3);
        wait_done();
        repeat (2) @(negedge clock);
        check("ignored_start_result", bus.result, 32'd142);

        // Reset in the middle of RUN abandons the operation.
        issue(`ALU_DIVU_OP, 32'd1000, 32'd7);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        sb_q.delete();
        busy_last = 0;
        #1;
        check("midrun_reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("midrun_reset_done",   {31'd0, bus.done}, 32'd0);
        check("midrun_reset_result", bus.result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("post_reset_idle_result", bus.result, 32'd0);
        issue(`ALU_MUL_OP, 32'd7, 32'd6);
        wait_done();

        // Random ops with random gaps, including back-to-back starts from DONE.
        for (int i = 0; i < 80; i++) begin
            o   = ops[$urandom_range(0, 8)];
            x   = rand_operand();
            y   = rand_operand();
            byp = ref_bypass(o, x, y);
            issue(o, x, y);
            if (!byp && $urandom_range(0, 3) == 0) begin
                repeat (3) @(negedge clock);
                issue(ops[$urandom_range(0, 8)], rand_operand(), rand_operand());
            end
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
